// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared cache geometry, refill FSM encodings and address-field slice positions
package icache_refill_pkg;

    localparam int I_INDEX_WIDTH = 4;
    localparam int I_WO_WIDTH    = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int OFF_LSB = 2;

    function automatic int idx_lsb(input int ow);
        return ow + OFF_LSB;
    endfunction

    function automatic int tag_lsb(input int iw, input int ow);
        return iw + ow + OFF_LSB;
    endfunction

endpackage

// File: rtl/icache_refill.sv
// icache_refill: streams one memory line into a 4-way I-cache data RAM after a miss
// Optional ICACHE_CRIT_WORD_FIRST_EN: critical-word-first request order plus crit_valid/crit_data early restart
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = I_INDEX_WIDTH,
    parameter int OW = I_WO_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          miss_valid,
    output logic          miss_ready,
    input  logic [AW-1:0] miss_addr,
    input  logic [1:0]    miss_way,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_resp_data,
    output logic [IW-1:0] ram_index,
    output logic [1:0]    ram_way,
    output logic [OW-1:0] ram_offset,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          ram_en,
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    output logic          crit_valid,
    output logic [DW-1:0] crit_data,
`endif
    output logic          refill_done
);

    localparam int IL = idx_lsb(OW);
    localparam int TL = tag_lsb(IW, OW);
    localparam int TW = AW - TL;
    localparam logic [OW:0] LAST = (OW+1)'((1 << OW) - 1);

    logic [1:0]    state;
    logic [OW:0]   cnt;
    logic [TW-1:0] tag_q;
    logic [IW-1:0] idx_q;
    logic [1:0]    way_q;
    logic [OW-1:0] off_q;
    logic [DW-1:0] din_q;
    logic          fill_wr;
    logic          unused;

    // A beat is written only while filling; the write path is purely combinational
    always_comb begin
        fill_wr       = (state == S_FILL) && mem_resp_valid;
        miss_ready    = state == S_IDLE;
        mem_req_valid = state == S_REQ;
        refill_done   = state == S_DONE;
        ram_index     = idx_q;
        ram_way       = way_q;
        ram_din       = fill_wr ? mem_resp_data : din_q;
        ram_we        = fill_wr;
        ram_en        = fill_wr;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
        mem_req_addr  = {tag_q, idx_q, off_q, 2'b00};
        ram_offset    = off_q + cnt[OW-1:0];
        crit_valid    = fill_wr && (cnt == '0);
        crit_data     = mem_resp_data;
        unused        = ^miss_addr[1:0];
`else
        mem_req_addr  = {tag_q, idx_q, {OW{1'b0}}, 2'b00};
        ram_offset    = cnt[OW-1:0];
        unused        = ^{miss_addr[1:0], off_q};
`endif
    end

    // Refill sequencing: latch the miss, hold the request, count beats, pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            tag_q <= '0;
            idx_q <= '0;
            way_q <= '0;
            off_q <= '0;
            din_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (miss_valid) begin
                    tag_q <= miss_addr[AW-1:TL];
                    idx_q <= miss_addr[TL-1:IL];
                    off_q <= miss_addr[IL-1:OFF_LSB];
                    way_q <= miss_way;
                    state <= S_REQ;
                end
                S_REQ: if (mem_req_ready) begin
                    cnt   <= '0;
                    state <= S_FILL;
                end
                S_FILL: if (mem_resp_valid) begin
                    cnt   <= cnt + (OW+1)'(1);
                    din_q <= mem_resp_data;
                    if (cnt == LAST) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
